picosoc_slotcfg_seq: RTL

//  PicoSoC memory-mapped peripheral that holds staged card assignments for NUM_SLOTS Apple II slots.

---
 rtl/picosoc_slotcfg_seq_if.sv | 14 +
 rtl/picosoc_slotcfg_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_slotcfg_seq_if.sv
// PicoSoC iomem bus bundle between the CPU and the slot configuration sequencer.
interface picosoc_slotcfg_seq_if;
   logic        iomem_valid;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        iomem_ready;

   modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   input  iomem_rdata, iomem_ready);
   modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   output iomem_rdata, iomem_ready);
endinterface

// File: rtl/picosoc_slotcfg_seq.sv
// Staged Apple II slot card assignments: firmware fills shadow registers, COMMIT
// pushes dirty slots to the slotmaker, pulses reconfig, settles, then raises irq.
module picosoc_slotcfg_seq #(
   parameter  int unsigned NUM_SLOTS       = 8,
   parameter  int unsigned CARD_W          = 8,
   parameter  int unsigned READY_LAT       = 3,
   parameter  int unsigned RECONFIG_CYCLES = 16,
   localparam int unsigned SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                 clk_i,
   input  logic                 resetn_i,
   picosoc_slotcfg_seq_if.slave bus,
   output logic [SLOT_W-1:0]    cfg_slot_o,
   output logic [CARD_W-1:0]    cfg_card_o,
   output logic                 cfg_wr_o,
   output logic                 cfg_reconfig_o,
   output logic                 irq_o
);
   localparam int unsigned LAT_W = (READY_LAT > 1) ? $clog2(READY_LAT) : 1;
   localparam int unsigned CNT_W = (RECONFIG_CYCLES > 1) ? $clog2(RECONFIG_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PUSH, S_KICK, S_SETTLE, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic                ready_q, ready_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [CARD_W-1:0]   shadow_q [NUM_SLOTS];
   logic [CARD_W-1:0]   shadow_d [NUM_SLOTS];
   logic [CARD_W-1:0]   active_q [NUM_SLOTS];
   logic [CARD_W-1:0]   active_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] dirty_q, dirty_d;
   logic                pend_q, pend_d;
   logic                irq_en_q, irq_en_d;
   logic                irq_pend_q, irq_pend_d;
   logic [7:0]          chg_q, chg_d;
   logic                cfg_wr_q, cfg_wr_d;
   logic                cfg_reconfig_q, cfg_reconfig_d;
   logic [SLOT_W-1:0]   cfg_slot_q, cfg_slot_d;
   logic [CARD_W-1:0]   cfg_card_q, cfg_card_d;
   logic                irq_q, irq_d;

   logic [3:0]          a;
   logic [3:0]          act_a;
   logic                acc;
   logic                ctrl_wr;
   logic                slot_wr;
   logic                commit;
   logic                unused_bus_bits;

   // Bus decode: side effects happen only on the cycle that produces ready.
   always_comb begin
      a       = bus.iomem_addr[5:2];
      act_a   = a - 4'd9;
      acc     = bus.iomem_valid && !ready_q && (lat_q == LAT_W'(READY_LAT - 1));
      ctrl_wr = acc && bus.iomem_wstrb[0] && (a == 4'd8);
      slot_wr = acc && bus.iomem_wstrb[0] && (32'(a) < NUM_SLOTS);
      commit  = ctrl_wr && bus.iomem_wdata[0];
   end

   assign unused_bus_bits = ^{bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb};

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      pend_d         = pend_q;
      shadow_d       = shadow_q;
      active_d       = active_q;
      dirty_d        = dirty_q;
      chg_d          = chg_q;
      irq_en_d       = irq_en_q;
      irq_pend_d     = irq_pend_q;
      cfg_wr_d       = 1'b0;
      cfg_reconfig_d = 1'b0;
      cfg_slot_d     = cfg_slot_q;
      cfg_card_d     = cfg_card_q;
      ready_d        = 1'b0;
      rdata_d        = '0;
      lat_d          = '0;

      if (bus.iomem_valid && !ready_q && !acc) lat_d = lat_q + LAT_W'(1);

      if (acc) begin
         ready_d = 1'b1;
         if (32'(a) < NUM_SLOTS)
            rdata_d = 32'(shadow_q[a[SLOT_W-1:0]]);
         else if (a == 4'd8)
            rdata_d = {8'd0, chg_q, 8'(dirty_q), 5'd0, irq_en_q, irq_pend_q, state_q != S_IDLE};
         else if ((a >= 4'd9) && (32'(act_a) < NUM_SLOTS))
            rdata_d = 32'(active_q[act_a[SLOT_W-1:0]]);
      end

      case (state_q)
         S_IDLE: begin
            if (commit || pend_q) begin
               state_d = S_PUSH;
               idx_d   = '0;
               pend_d  = 1'b0;
            end
         end
         S_PUSH: begin
            if (dirty_q[idx_q]) begin
               cfg_wr_d        = 1'b1;
               cfg_slot_d      = idx_q;
               cfg_card_d      = shadow_q[idx_q];
               active_d[idx_q] = shadow_q[idx_q];
               dirty_d[idx_q]  = 1'b0;
            end
            if (idx_q == SLOT_W'(NUM_SLOTS - 1)) state_d = S_KICK;
            else                                 idx_d   = idx_q + SLOT_W'(1);
         end
         S_KICK: begin
            cfg_reconfig_d = 1'b1;
            cnt_d          = '0;
            state_d        = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(RECONFIG_CYCLES - 1)) state_d = S_DONE;
            else                                      cnt_d   = cnt_q + CNT_W'(1);
         end
         S_DONE: begin
            chg_d = chg_q + 8'd1;
            // A commit that arrived while busy restarts the push without going idle.
            if (pend_q || commit) begin
               state_d = S_PUSH;
               idx_d   = '0;
               pend_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (commit && (state_q != S_IDLE) && (state_q != S_DONE)) pend_d = 1'b1;

      if (ctrl_wr) begin
         irq_en_d = bus.iomem_wdata[2];
         if (bus.iomem_wdata[1]) irq_pend_d = 1'b0;
      end
      if (state_q == S_DONE) irq_pend_d = 1'b1;

      // Applied after the push clear so a same-cycle shadow write keeps the slot dirty.
      if (slot_wr) begin
         shadow_d[a[SLOT_W-1:0]] = bus.iomem_wdata[CARD_W-1:0];
         dirty_d[a[SLOT_W-1:0]]  = 1'b1;
      end

      irq_d = irq_pend_d & irq_en_d;
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         cnt_q          <= '0;
         lat_q          <= '0;
         ready_q        <= 1'b0;
         rdata_q        <= '0;
         shadow_q       <= '{default: '0};
         active_q       <= '{default: '0};
         dirty_q        <= '0;
         pend_q         <= 1'b0;
         irq_en_q       <= 1'b0;
         irq_pend_q     <= 1'b0;
         chg_q          <= '0;
         cfg_wr_q       <= 1'b0;
         cfg_reconfig_q <= 1'b0;
         cfg_slot_q     <= '0;
         cfg_card_q     <= '0;
         irq_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         lat_q          <= lat_d;
         ready_q        <= ready_d;
         rdata_q        <= rdata_d;
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         dirty_q        <= dirty_d;
         pend_q         <= pend_d;
         irq_en_q       <= irq_en_d;
         irq_pend_q     <= irq_pend_d;
         chg_q          <= chg_d;
         cfg_wr_q       <= cfg_wr_d;
         cfg_reconfig_q <= cfg_reconfig_d;
         cfg_slot_q     <= cfg_slot_d;
         cfg_card_q     <= cfg_card_d;
         irq_q          <= irq_d;
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign cfg_wr_o        = cfg_wr_q;
   assign cfg_reconfig_o  = cfg_reconfig_q;
   assign cfg_slot_o      = cfg_slot_q;
   assign cfg_card_o      = cfg_card_q;
   assign irq_o           = irq_q;
endmodule
